// File: rtl/cobra_ctrl_pkg.sv
// Shared types and widths for the CYBERcobra run controller.
package cobra_ctrl_pkg;

  localparam int PC_W   = 32;
  localparam int ICNT_W = 32;

  // Controller state as exposed on state_o.
  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_HALTED = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } run_state_t;

  localparam logic [ICNT_W-1:0] ICNT_MAX = '1;

  // Retired-instruction counter increment that sticks at all-ones.
  function automatic logic [ICNT_W-1:0] sat_inc(input logic [ICNT_W-1:0] value);
    return (value == ICNT_MAX) ? value : value + ICNT_W'(1);
  endfunction

endpackage

// File: rtl/cobra_edge_det.sv
// One-bit rising-edge detector for a debounced level request.
// The history flop resets to 1 so a request already held high while the
// controller comes out of reset is not mistaken for a fresh press.
module cobra_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  // Remember last cycle's level of the request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/cobra_run_ctrl.sv
// Run controller for the CYBERcobra core: reset hold, run/halt/single-step,
// PC breakpoint, retired-instruction counter and an optional watchdog.
// core_en_o and core_rst_o are decoded from the state register together with
// this cycle's stop conditions so a breakpointed instruction never commits.
module cobra_run_ctrl
  import cobra_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned AUTORUN     = 0,
  parameter int unsigned CYCLE_LIMIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic             wdt_o,
  output logic [ICNT_W-1:0] icount_o
);

  localparam logic [7:0]        HOLD_LAST  = 8'(RST_HOLD - 1);
  localparam run_state_t        AUTO_STATE = (AUTORUN != 0) ? ST_RUN : ST_HALTED;
  localparam logic              WDT_ON     = (CYCLE_LIMIT != 0);
  localparam logic [ICNT_W-1:0] WDT_LIMIT  = ICNT_W'(CYCLE_LIMIT);

  logic [1:0]        rst_sync_q;
  logic              rst_n_sync;
  logic              run_edge;
  logic              halt_edge;
  logic              step_edge;
  logic              bp_match;
  logic              wdt_match;
  logic              stop;
  run_state_t        state_q;
  logic [7:0]        hold_cnt_q;
  logic              bp_skip_q;
  logic              bp_hit_q;
  logic              wdt_q;
  logic [ICNT_W-1:0] icount_q;

  // Assert reset immediately, release it two clocks after rst_i rises.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = rst_sync_q[1];

  cobra_edge_det u_run_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_n_sync),
    .d_i    (run_i),
    .edge_o (run_edge)
  );

  cobra_edge_det u_halt_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_n_sync),
    .d_i    (halt_i),
    .edge_o (halt_edge)
  );

  cobra_edge_det u_step_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_n_sync),
    .d_i    (step_i),
    .edge_o (step_edge)
  );

  // bp_skip masks the watchdog as well as the breakpoint: after a watchdog
  // halt the count stays at or above the limit, so the first instruction of
  // a resumed run must be let through before the limit can bite again.
  assign bp_match  = bp_en_i & (pc_i == bp_addr_i) & ~bp_skip_q;
  assign wdt_match = WDT_ON & (icount_q >= WDT_LIMIT) & ~bp_skip_q;
  assign stop      = halt_edge | bp_match | wdt_match;

  assign core_rst_o = (state_q == ST_HOLD);
  assign core_en_o  = ((state_q == ST_RUN) & ~stop) | (state_q == ST_STEP);
  assign halted_o   = (state_q == ST_HALTED);
  assign state_o    = state_q;
  assign bp_hit_o   = bp_hit_q;
  assign wdt_o      = wdt_q;
  assign icount_o   = icount_q;

  // Controller FSM with reset-hold counter, sticky halt flags and resume skip.
  always_ff @(posedge clk_i or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      bp_skip_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      wdt_q      <= 1'b0;
    end else begin
      if (core_en_o) begin
        bp_skip_q <= 1'b0;
      end
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= AUTO_STATE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        ST_HALTED: begin
          if (!halt_edge && (step_edge || run_edge)) begin
            state_q   <= step_edge ? ST_STEP : ST_RUN;
            bp_hit_q  <= 1'b0;
            wdt_q     <= 1'b0;
            bp_skip_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bp_match) begin
            bp_hit_q <= 1'b1;
          end
          if (wdt_match) begin
            wdt_q <= 1'b1;
          end
          if (stop) begin
            state_q <= ST_HALTED;
          end
        end
        ST_STEP: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  // Count every committed instruction, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      icount_q <= '0;
    end else if (core_en_o) begin
      icount_q <= sat_inc(icount_q);
    end
  end

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Scoreboarded bench for cobra_run_ctrl: a cycle-level behavioural model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_cobra_run_ctrl;

  localparam int HOLD_N   = 4;
  localparam int LIMIT    = 10;
  localparam int S_HOLD   = 0;
  localparam int S_HALTED = 1;
  localparam int S_RUN    = 2;
  localparam int S_STEP   = 3;

  logic        clk_i;
  logic        rst_i;
  logic        run_i;
  logic        halt_i;
  logic        step_i;
  logic        bp_en_i;
  logic [31:0] bp_addr_i;
  logic [31:0] pc_i;
  logic        core_rst_o;
  logic        core_en_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic        bp_hit_o;
  logic        wdt_o;
  logic [31:0] icount_o;
  logic        auto_core_rst;
  logic        auto_core_en;
  logic [1:0]  auto_state;
  logic        auto_halted;
  logic        auto_bp_hit;
  logic        auto_wdt;
  logic [31:0] auto_icount;

  typedef struct packed {
    logic        core_rst;
    logic        core_en;
    logic [1:0]  state;
    logic        halted;
    logic        bp_hit;
    logic        wdt;
    logic [31:0] icount;
  } out_t;

  out_t exp_q[$];
  out_t snap;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  int              m_sync;
  int              m_hold;
  int              m_state;
  bit              m_prev_run;
  bit              m_prev_halt;
  bit              m_prev_step;
  bit              m_skip;
  bit              m_bp;
  bit              m_wdt;
  longint unsigned m_icnt;
  logic [31:0]     m_pc;

  cobra_run_ctrl #(.RST_HOLD(HOLD_N), .AUTORUN(0), .CYCLE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
    .core_rst_o(core_rst_o), .core_en_o(core_en_o), .state_o(state_o),
    .halted_o(halted_o), .bp_hit_o(bp_hit_o), .wdt_o(wdt_o), .icount_o(icount_o)
  );

  cobra_run_ctrl #(.RST_HOLD(HOLD_N), .AUTORUN(1), .CYCLE_LIMIT(LIMIT)) dut_auto (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
    .core_rst_o(auto_core_rst), .core_en_o(auto_core_en), .state_o(auto_state),
    .halted_o(auto_halted), .bp_hit_o(auto_bp_hit), .wdt_o(auto_wdt), .icount_o(auto_icount)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic out_t dutOut();
    out_t o;
    o.core_rst = core_rst_o;
    o.core_en  = core_en_o;
    o.state    = state_o;
    o.halted   = halted_o;
    o.bp_hit   = bp_hit_o;
    o.wdt      = wdt_o;
    o.icount   = icount_o;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic modelReset();
    m_sync      = 0;
    m_hold      = 0;
    m_state     = S_HOLD;
    m_prev_run  = 1'b1;
    m_prev_halt = 1'b1;
    m_prev_step = 1'b1;
    m_skip      = 1'b0;
    m_bp        = 1'b0;
    m_wdt       = 1'b0;
    m_icnt      = 0;
    m_pc        = 32'h0;
  endtask

  // Predict this cycle's outputs, then move the model past the next clock.
  task automatic modelCycle(output out_t e);
    bit run_e, halt_e, step_e, bpm, wdm, en;
    if (!rst_i) modelReset();
    run_e  = run_i && !m_prev_run;
    halt_e = halt_i && !m_prev_halt;
    step_e = step_i && !m_prev_step;
    bpm    = bp_en_i && (pc_i == bp_addr_i) && !m_skip;
    wdm    = (LIMIT != 0) && (m_icnt >= LIMIT) && !m_skip;
    en     = (m_state == S_RUN && !(halt_e || bpm || wdm)) || (m_state == S_STEP);
    e.core_rst = (m_state == S_HOLD);
    e.core_en  = en;
    e.state    = 2'(m_state);
    e.halted   = (m_state == S_HALTED);
    e.bp_hit   = m_bp;
    e.wdt      = m_wdt;
    e.icount   = 32'(m_icnt);
    if (!rst_i) return;
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    if (en) begin
      if (m_icnt != 64'hFFFF_FFFF) m_icnt++;
      m_skip = 1'b0;
      m_pc   = m_pc + 32'd4;
    end
    case (m_state)
      S_HOLD: begin
        m_hold++;
        if (m_hold == HOLD_N) m_state = S_HALTED;
      end
      S_HALTED: begin
        if (!halt_e && (step_e || run_e)) begin
          m_state = step_e ? S_STEP : S_RUN;
          m_bp    = 1'b0;
          m_wdt   = 1'b0;
          m_skip  = 1'b1;
        end
      end
      S_RUN: begin
        if (bpm) m_bp = 1'b1;
        if (wdm) m_wdt = 1'b1;
        if (halt_e || bpm || wdm) m_state = S_HALTED;
      end
      default: m_state = S_HALTED;
    endcase
    m_prev_run  = run_i;
    m_prev_halt = halt_i;
    m_prev_step = step_i;
  endtask

  task automatic applyStimulus(input logic rst, input logic run, input logic halt, input logic step,
                               input logic bp_en, input logic [31:0] bp_addr);
    out_t e;
    @(negedge clk_i);
    if (m_pc >= 32'h40) m_pc = 32'h0;
    rst_i     = rst;
    run_i     = run;
    halt_i    = halt;
    step_i    = step;
    bp_en_i   = bp_en;
    bp_addr_i = bp_addr;
    pc_i      = m_pc;
    #1;
    cyc++;
    modelCycle(e);
    exp_q.push_back(e);
    snap = dutOut();
  endtask

  task automatic idle(input int n, input logic bp_en, input logic [31:0] bp_addr);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, bp_en, bp_addr);
  endtask

  // Release reset and measure how long core_rst_o stays high (sync + hold).
  task automatic checkHoldSequence();
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (snap.core_rst) n++;
      else break;
    end
    checkOutput("hold cycles", 64'(n), 64'(HOLD_N + 2));
    checkOutput("halted after hold", 64'(snap.halted), 64'd1);
    checkOutput("autorun state after hold", 64'(auto_state), 64'(S_RUN));
    checkOutput("icount after hold", 64'(snap.icount), 64'd0);
  endtask

  task automatic resetAndHold();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkHoldSequence();
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  initial begin
    out_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("outputs cycle %0d", cyc), 64'(dutOut()), 64'(e));
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int   pulses;
    logic r_run, r_halt, r_step, r_bp_en;
    logic [31:0] r_bp_addr;

    rst_i = 1'b0; run_i = 1'b0; halt_i = 1'b0; step_i = 1'b0;
    bp_en_i = 1'b0; bp_addr_i = 32'h0; pc_i = 32'h0;
    modelReset();

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset outputs", 64'(snap), 64'({1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0}));
    checkHoldSequence();

    $display("[TB] three single steps");
    pulses = 0;
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      pulses += int'(snap.core_en);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      pulses += int'(snap.core_en);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      pulses += int'(snap.core_en);
      checkOutput("halted after step", 64'(snap.halted), 64'd1);
    end
    checkOutput("step pulses", 64'(pulses), 64'd3);
    checkOutput("icount after steps", 64'(snap.icount), 64'd3);

    $display("[TB] breakpoint at 0x10 then watchdog");
    resetAndHold();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
    idle(6, 1'b1, 32'h10);
    checkOutput("bp_hit set", 64'(snap.bp_hit), 64'd1);
    checkOutput("icount at breakpoint", 64'(snap.icount), 64'd4);
    checkOutput("halted at breakpoint", 64'(snap.halted), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
    idle(1, 1'b1, 32'h10);
    checkOutput("resume executes bp pc", 64'({pc_i, snap.core_en}), 64'({32'h10, 1'b1}));
    idle(8, 1'b1, 32'h10);
    checkOutput("wdt set", 64'(snap.wdt), 64'd1);
    checkOutput("icount at watchdog", 64'(snap.icount), 64'(LIMIT));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
    idle(1, 1'b1, 32'h10);
    checkOutput("wdt cleared by run", 64'({snap.wdt, snap.core_en}), 64'({1'b0, 1'b1}));
    idle(2, 1'b1, 32'h10);
    checkOutput("wdt set again", 64'({snap.wdt, snap.halted}), 64'({1'b1, 1'b1}));
    checkOutput("icount one past limit", 64'(snap.icount), 64'(LIMIT + 1));

    $display("[TB] simultaneous requests in RUN and async reset");
    resetAndHold();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("no commit on halt edge", 64'(snap.core_en), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("halted after triple edge", 64'({snap.state, snap.core_en}), 64'({2'd1, 1'b0}));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("no step pulse", 64'(snap.core_en), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i);
    #1;
    checkOutput("running before reset pulse", 64'(core_en_o), 64'd1);
    rst_i = 1'b0;
    #2;
    checkOutput("async reset drops enable", 64'({core_en_o, core_rst_o}), 64'({1'b0, 1'b1}));
    checkOutput("async reset clears icount", 64'(icount_o), 64'd0);
    modelReset();
    checkHoldSequence();

    $display("[TB] randomized traffic");
    r_run = 1'b0; r_halt = 1'b0; r_step = 1'b0; r_bp_en = 1'b0; r_bp_addr = 32'h10;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r_run = ~r_run;
      if ($urandom_range(0, 5) == 0) r_halt = ~r_halt;
      if ($urandom_range(0, 3) == 0) r_step = ~r_step;
      if ($urandom_range(0, 15) == 0) r_bp_en = ~r_bp_en;
      if ($urandom_range(0, 15) == 0) r_bp_addr = 32'($urandom_range(0, 15)) << 2;
      applyStimulus(($urandom_range(0, 59) != 0), r_run, r_halt, r_step, r_bp_en, r_bp_addr);
    end
    idle(2, 1'b0, 32'h0);

    @(negedge clk_i);
    #3;
    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
